timekeeper_hms: RTL and testbench

TIMEKEEPER_HMS -- requirements
Module: timekeeper_hms

---
 rtl/timekeeper_hms.sv | 160 ++++++++++++++++
 tb/tb_timekeeper_hms.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timekeeper_hms.sv
// Hours/minutes/seconds timekeeper with a TICK_DIV prescaler, 12h/24h display and validated time load.
// Define TIMEKEEPER_ALARM_EN to build in the hh:mm alarm (alarm ports exist in both builds).
module timekeeper_hms #(
    parameter int unsigned TICK_DIV = 32'd50000000,
    parameter int unsigned PRE_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       mode_12h,
    input  logic       load,
    input  logic [4:0] load_hrs,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       alarm_set,
    input  logic       alarm_ack,
    input  logic [4:0] alarm_hrs_in,
    input  logic [5:0] alarm_min_in,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hrs,
    output logic [4:0] disp_hrs,
    output logic       pm,
    output logic       sec_pulse,
    output logic       load_err,
    output logic       alarm_out
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 32'd1);

    logic [PRE_W-1:0] r_pre;
    logic [5:0]       r_sec;
    logic [5:0]       r_min;
    logic [4:0]       r_hrs;
    logic             r_sec_pulse;
    logic             r_load_err;

    logic             w_term;
    logic             w_load_ok;
    logic             w_advance;
    logic             w_alarm_rej;
    logic [5:0]       w_nsec;
    logic [5:0]       w_nmin;
    logic [4:0]       w_nhrs;
    logic [4:0]       w_disp;

    assign w_term    = tick_en && (r_pre == PRE_LAST);
    assign w_load_ok = (load_hrs <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
    assign w_advance = !load && w_term;

    // Time one second ahead of the current registers, with full carry chain.
    always_comb begin
        w_nsec = r_sec + 6'd1;
        w_nmin = r_min;
        w_nhrs = r_hrs;
        if (r_sec == 6'd59) begin
            w_nsec = 6'd0;
            w_nmin = r_min + 6'd1;
            if (r_min == 6'd59) begin
                w_nmin = 6'd0;
                w_nhrs = (r_hrs == 5'd23) ? 5'd0 : r_hrs + 5'd1;
            end
        end
    end

    // A load, valid or not, blocks both the prescaler and the second advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre       <= '0;
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hrs       <= 5'd0;
            r_sec_pulse <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            r_load_err  <= w_alarm_rej;
            if (load) begin
                if (w_load_ok) begin
                    r_sec <= load_sec;
                    r_min <= load_min;
                    r_hrs <= load_hrs;
                    r_pre <= '0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (tick_en) begin
                if (w_term) begin
                    r_pre       <= '0;
                    r_sec       <= w_nsec;
                    r_min       <= w_nmin;
                    r_hrs       <= w_nhrs;
                    r_sec_pulse <= 1'b1;
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    end

`ifdef TIMEKEEPER_ALARM_EN
    logic [4:0] r_alarm_hrs;
    logic [5:0] r_alarm_min;
    logic       r_armed;
    logic       r_alarm_out;
    logic       w_alarm_hit;

    assign w_alarm_rej = alarm_set && !((alarm_hrs_in <= 5'd23) && (alarm_min_in <= 6'd59));
    assign w_alarm_hit = r_armed && w_advance && (w_nsec == 6'd0) &&
                         (w_nmin == r_alarm_min) && (w_nhrs == r_alarm_hrs);

    // Only a second advance can trigger; a match beats a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm_hrs <= 5'd0;
            r_alarm_min <= 6'd0;
            r_armed     <= 1'b0;
            r_alarm_out <= 1'b0;
        end else begin
            if (alarm_set && !w_alarm_rej) begin
                r_alarm_hrs <= alarm_hrs_in;
                r_alarm_min <= alarm_min_in;
                r_armed     <= 1'b1;
            end
            if (w_alarm_hit) begin
                r_alarm_out <= 1'b1;
            end else if (alarm_ack) begin
                r_alarm_out <= 1'b0;
            end
        end
    end

    assign alarm_out = r_alarm_out;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = ^{alarm_set, alarm_ack, alarm_hrs_in, alarm_min_in};
    assign w_alarm_rej    = 1'b0;
    assign alarm_out      = 1'b0;
`endif

    always_comb begin
        w_disp = r_hrs;
        if (mode_12h) begin
            if (r_hrs == 5'd0) begin
                w_disp = 5'd12;
            end else if (r_hrs > 5'd12) begin
                w_disp = r_hrs - 5'd12;
            end
        end
    end

    assign sec       = r_sec;
    assign min       = r_min;
    assign hrs       = r_hrs;
    assign disp_hrs  = w_disp;
    assign pm        = (r_hrs >= 5'd12);
    assign sec_pulse = r_sec_pulse;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_timekeeper_hms.sv
// Self-checking bench for timekeeper_hms (TICK_DIV=4): directed tables and sequences plus
// random stimulus against a seconds-of-day reference model; honours TIMEKEEPER_ALARM_EN.
module tb_timekeeper_hms;

    localparam int TICK_DIV = 4;
`ifdef TIMEKEEPER_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, tick_en, mode_12h, load, alarm_set, alarm_ack;
    logic [4:0] load_hrs, alarm_hrs_in;
    logic [5:0] load_min, load_sec, alarm_min_in;
    logic [5:0] sec, min;
    logic [4:0] hrs, disp_hrs;
    logic       pm, sec_pulse, load_err, alarm_out;

    always #5 clk = ~clk;

    timekeeper_hms #(.TICK_DIV(TICK_DIV), .PRE_W(3)) dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .mode_12h(mode_12h),
        .load(load), .load_hrs(load_hrs), .load_min(load_min), .load_sec(load_sec),
        .alarm_set(alarm_set), .alarm_ack(alarm_ack),
        .alarm_hrs_in(alarm_hrs_in), .alarm_min_in(alarm_min_in),
        .sec(sec), .min(min), .hrs(hrs), .disp_hrs(disp_hrs), .pm(pm),
        .sec_pulse(sec_pulse), .load_err(load_err), .alarm_out(alarm_out)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference state: time as seconds since midnight, alarm as minutes since midnight.
    int mSecs = 0, mPre = 0, mAlarmMin = 0;
    bit mPulse = 0, mErr = 0, mAlarmOut = 0, mArmed = 0;
    bit curMode = 0;

    typedef struct {
        int lh, lm, ls;
        int eh, em, es;
        bit eErr;
        int eDisp;
        bit ePm;
    } loadVec_t;
    loadVec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        bit adv;
        bit hit;
        adv = 1'b0;
        if (reset) begin
            mSecs = 0; mPre = 0; mPulse = 0; mErr = 0;
            mAlarmOut = 0; mArmed = 0; mAlarmMin = 0;
            return;
        end
        mPulse = 0;
        mErr   = 0;
        if (load) begin
            if (load_hrs <= 23 && load_min <= 59 && load_sec <= 59) begin
                mSecs = int'(load_hrs) * 3600 + int'(load_min) * 60 + int'(load_sec);
                mPre  = 0;
            end else begin
                mErr = 1;
            end
        end else if (tick_en) begin
            if (mPre == TICK_DIV - 1) begin
                mPre   = 0;
                mSecs  = (mSecs + 1) % 86400;
                mPulse = 1;
                adv    = 1'b1;
            end else begin
                mPre++;
            end
        end
        if (ALARM) begin
            hit = adv && mArmed && (mSecs == mAlarmMin * 60);
            if (hit) mAlarmOut = 1;
            else if (alarm_ack) mAlarmOut = 0;
            if (alarm_set) begin
                if (alarm_hrs_in <= 23 && alarm_min_in <= 59) begin
                    mAlarmMin = int'(alarm_hrs_in) * 60 + int'(alarm_min_in);
                    mArmed    = 1;
                end else begin
                    mErr = 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        int h;
        int d;
        h = mSecs / 3600;
        d = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        check({tag, ".sec"}, int'(sec), mSecs % 60);
        check({tag, ".min"}, int'(min), (mSecs / 60) % 60);
        check({tag, ".hrs"}, int'(hrs), h);
        check({tag, ".disp"}, int'(disp_hrs), d);
        check({tag, ".pm"}, int'(pm), (h >= 12) ? 1 : 0);
        check({tag, ".pulse"}, int'(sec_pulse), int'(mPulse));
        check({tag, ".err"}, int'(load_err), int'(mErr));
        check({tag, ".alarm"}, int'(alarm_out), int'(mAlarmOut));
    endtask

    task automatic applyStimulus(input bit rst, input bit te, input bit ld,
                                 input int lh, input int lm, input int ls,
                                 input bit as, input bit ak, input int ah, input int am,
                                 input string tag);
        reset        = rst;
        tick_en      = te;
        mode_12h     = curMode;
        load         = ld;
        load_hrs     = 5'(lh);
        load_min     = 6'(lm);
        load_sec     = 6'(ls);
        alarm_set    = as;
        alarm_ack    = ak;
        alarm_hrs_in = 5'(ah);
        alarm_min_in = 6'(am);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput(tag);
    endtask

    task automatic tick(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic doLoad(input int h, input int m, input int s, input bit te, input string tag);
        applyStimulus(0, te, 1, h, m, s, 0, 0, 0, 0, tag);
    endtask

    initial begin
        vecs[0] = '{23, 59, 59, 23, 59, 59, 0, 11, 1};
        vecs[1] = '{24,  0,  0, 23, 59, 59, 1, 11, 1};
        vecs[2] = '{12,  5, 60, 23, 59, 59, 1, 11, 1};
        vecs[3] = '{10,  0,  0, 10,  0,  0, 0, 10, 0};
        vecs[4] = '{ 0, 60,  0, 10,  0,  0, 1, 10, 0};
        vecs[5] = '{12,  0,  0, 12,  0,  0, 0, 12, 1};
        vecs[6] = '{ 0,  0,  0,  0,  0,  0, 0, 12, 0};
        vecs[7] = '{13,  7, 30, 13,  7, 30, 0,  1, 1};
        vecs[8] = '{31, 63, 63, 13,  7, 30, 1,  1, 1};
        vecs[9] = '{11, 59, 59, 11, 59, 59, 0, 11, 0};

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        check("reset.sec0", int'(sec), 0);
        check("reset.hrs0", int'(hrs), 0);

        // Twelve enabled cycles give three isolated pulses four cycles apart.
        begin
            int pulses;
            pulses = 0;
            for (int k = 1; k <= 12; k++) begin
                tick(1, "r033");
                check("r033.pulsePos", int'(sec_pulse), (k % 4 == 0) ? 1 : 0);
                pulses += int'(sec_pulse);
            end
            check("r033.sec", int'(sec), 3);
            check("r033.count", pulses, 3);
        end

        curMode = 1;
        foreach (vecs[i]) begin
            doLoad(vecs[i].lh, vecs[i].lm, vecs[i].ls, 0, "loadTbl");
            check("loadTbl.hrs", int'(hrs), vecs[i].eh);
            check("loadTbl.min", int'(min), vecs[i].em);
            check("loadTbl.sec", int'(sec), vecs[i].es);
            check("loadTbl.err", int'(load_err), int'(vecs[i].eErr));
            check("loadTbl.disp", int'(disp_hrs), vecs[i].eDisp);
            check("loadTbl.pm", int'(pm), int'(vecs[i].ePm));
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "loadTbl.idle");
            check("loadTbl.errOnce", int'(load_err), 0);
        end

        doLoad(23, 59, 59, 0, "r034");
        check("r034.pmBefore", int'(pm), 1);
        check("r034.dispBefore", int'(disp_hrs), 11);
        tick(4, "r034");
        check("r034.hrs", int'(hrs), 0);
        check("r034.min", int'(min), 0);
        check("r034.sec", int'(sec), 0);
        check("r034.pmAfter", int'(pm), 0);
        check("r034.dispAfter", int'(disp_hrs), 12);

        tick(3, "r036.pre");
        doLoad(10, 0, 0, 1, "r036");
        check("r036.hrs", int'(hrs), 10);
        check("r036.sec", int'(sec), 0);
        check("r036.noPulse", int'(sec_pulse), 0);
        for (int k = 1; k <= 4; k++) begin
            tick(1, "r036.after");
            check("r036.pulsePos", int'(sec_pulse), (k == 4) ? 1 : 0);
        end
        check("r036.sec1", int'(sec), 1);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 7, 30, "r037.set");
        doLoad(7, 29, 59, 0, "r037.load");
        tick(4, "r037.run");
        check("r037.fire", int'(alarm_out), ALARM ? 1 : 0);
        tick(3, "r037.hold");
        check("r037.hold", int'(alarm_out), ALARM ? 1 : 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "r037.ack");
        check("r037.ack", int'(alarm_out), 0);
        doLoad(7, 29, 59, 0, "matchAck.load");
        tick(3, "matchAck.run");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, "matchAck");
        check("matchAck.wins", int'(alarm_out), ALARM ? 1 : 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "matchAck.ack");
        doLoad(7, 30, 0, 0, "loadOnAlarm");
        check("loadOnAlarm.quiet", int'(alarm_out), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 24, 0, "badAlarm");
        check("badAlarm.err", int'(load_err), ALARM ? 1 : 0);
        doLoad(7, 29, 59, 0, "keepAlarm.load");
        tick(4, "keepAlarm.run");
        check("keepAlarm.fire", int'(alarm_out), ALARM ? 1 : 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "keepAlarm.ack");

        doLoad(13, 7, 30, 0, "r038.load");
        tick(2, "r038.pre");
        applyStimulus(1, 1, 1, 10, 0, 0, 1, 0, 7, 30, "r038");
        check("r038.sec", int'(sec), 0);
        check("r038.min", int'(min), 0);
        check("r038.hrs", int'(hrs), 0);
        check("r038.pm", int'(pm), 0);
        check("r038.err", int'(load_err), 0);
        check("r038.alarm", int'(alarm_out), 0);
        for (int k = 1; k <= 4; k++) begin
            tick(1, "r026");
            check("r026.pulsePos", int'(sec_pulse), (k == 4) ? 1 : 0);
        end

        // Random traffic; loads and alarms are biased toward 07:29:5x / 07:30 to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            bit rst, te, ld, as, ak;
            int lh, lm, ls, ah, am;
            if (i % 50 == 0) curMode = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            te  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 29) == 0);
            as  = ($urandom_range(0, 59) == 0);
            ak  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) begin
                lh = 7; lm = 29; ls = $urandom_range(56, 59);
            end else begin
                lh = $urandom_range(0, 25); lm = $urandom_range(0, 61); ls = $urandom_range(0, 61);
            end
            if ($urandom_range(0, 3) == 0) begin
                ah = $urandom_range(0, 25); am = $urandom_range(0, 61);
            end else begin
                ah = 7; am = 30;
            end
            applyStimulus(rst, te, ld, lh, lm, ls, as, ak, ah, am, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
